// File: rtl/edge_trigger_hyst.sv
// rtl/edge_trigger_hyst.sv - moving-sum edge trigger with hysteresis level, qualification and Nth-edge pulse

module edge_trigger_hyst #(
    parameter int ADC_WIDTH = 10,
    parameter int WIN_LOG2  = 8,
    parameter int CNT_WIDTH = 8,
    localparam int SUM_WIDTH = ADC_WIDTH + WIN_LOG2
) (
    input  logic                 clk,
    input  logic                 reset_i,
    input  logic [ADC_WIDTH-1:0] adc_data,
    input  logic                 adc_valid,
    input  logic                 cfg_arm,
    input  logic                 cfg_abort,
    input  logic [WIN_LOG2-1:0]  cfg_window,
    input  logic                 cfg_abs,
    input  logic [1:0]           cfg_mode,
    input  logic [SUM_WIDTH-1:0] cfg_thresh_hi,
    input  logic [SUM_WIDTH-1:0] cfg_thresh_lo,
    input  logic [CNT_WIDTH-1:0] cfg_qualify,
    input  logic [CNT_WIDTH-1:0] cfg_edge_num,
    input  logic                 cfg_rearm,
    output logic                 trig_out,
    output logic [SUM_WIDTH-1:0] sum_out,
    output logic                 sum_valid,
    output logic                 level_o,
    output logic [CNT_WIDTH-1:0] edge_cnt_o,
    output logic [1:0]           state_o
);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_FILL  = 2'd1,
        S_ARMED = 2'd2,
        S_DONE  = 2'd3
    } state_t;

    localparam logic [ADC_WIDTH-1:0] MID = {1'b1, {(ADC_WIDTH-1){1'b0}}};

    // sample history; contents before a fill completes are never read
    logic [ADC_WIDTH-1:0] mem [0:(1<<WIN_LOG2)-1];

    state_t               state_q, state_d;
    logic [WIN_LOG2-1:0]  wr_ptr_q, wr_ptr_d;
    logic [WIN_LOG2-1:0]  fill_cnt_q, fill_cnt_d;
    logic [SUM_WIDTH-1:0] sum_q, sum_d;
    logic                 sum_valid_q, sum_valid_d;
    logic                 eval_q, eval_d;
    logic                 level_q, level_d;
    logic                 trig_q, trig_d;
    logic [CNT_WIDTH-1:0] edge_cnt_q, edge_cnt_d;
    logic [CNT_WIDTH-1:0] qual_cnt_q, qual_cnt_d;

    logic [WIN_LOG2-1:0]  win_eff;
    logic [CNT_WIDTH-1:0] qual_eff;
    logic [CNT_WIDTH-1:0] edge_num_eff;
    logic [ADC_WIDTH-1:0] sample;
    logic [ADC_WIDTH-1:0] s_old;
    logic [WIN_LOG2-1:0]  rd_ptr;
    logic [WIN_LOG2-1:0]  fill_p1;
    logic [SUM_WIDTH-1:0] sum_calc;
    logic [CNT_WIDTH:0]   qual_p1;
    logic [CNT_WIDTH:0]   edge_p1;
    logic                 accept;
    logic                 do_eval;
    logic                 cand;
    logic                 edge_match;

    // zero-valued config fields mean "one"
    assign win_eff      = (cfg_window   == '0) ? WIN_LOG2'(1)  : cfg_window;
    assign qual_eff     = (cfg_qualify  == '0) ? CNT_WIDTH'(1) : cfg_qualify;
    assign edge_num_eff = (cfg_edge_num == '0) ? CNT_WIDTH'(1) : cfg_edge_num;

    // sample conditioning, oldest-sample lookup and the running-sum update
    assign sample   = cfg_abs ? ((adc_data >= MID) ? (adc_data - MID) : (MID - adc_data)) : adc_data;
    assign rd_ptr   = wr_ptr_q - win_eff;
    assign s_old    = (fill_cnt_q >= win_eff) ? mem[rd_ptr] : '0;
    assign sum_calc = sum_q + SUM_WIDTH'(sample) - SUM_WIDTH'(s_old);
    assign fill_p1  = fill_cnt_q + WIN_LOG2'(1);

    // arm and abort both pre-empt any sample or commit in the same cycle
    assign accept  = adc_valid && (state_q != S_IDLE) && !cfg_arm && !cfg_abort;
    assign do_eval = eval_q && (state_q == S_ARMED) && !cfg_arm && !cfg_abort;

    // hysteresis candidate from the registered sum; hi threshold wins a tie
    assign cand = (sum_q > cfg_thresh_hi) ? 1'b1 :
                  (sum_q < cfg_thresh_lo) ? 1'b0 : level_q;

    assign qual_p1 = {1'b0, qual_cnt_q} + (CNT_WIDTH+1)'(1);
    assign edge_p1 = {1'b0, edge_cnt_q} + (CNT_WIDTH+1)'(1);

    // the committed toggle direction equals cand; mode 3 behaves as rising
    always_comb begin
        case (cfg_mode)
            2'd1:    edge_match = !cand;
            2'd2:    edge_match = 1'b1;
            default: edge_match = cand;
        endcase
    end

    // next-state, moving sum, qualification and edge counting
    always_comb begin
        state_d     = state_q;
        wr_ptr_d    = wr_ptr_q;
        fill_cnt_d  = fill_cnt_q;
        sum_d       = sum_q;
        sum_valid_d = 1'b0;
        eval_d      = 1'b0;
        level_d     = level_q;
        trig_d      = 1'b0;
        edge_cnt_d  = edge_cnt_q;
        qual_cnt_d  = qual_cnt_q;

        if (cfg_abort) begin
            state_d = S_IDLE;
        end else if (cfg_arm) begin
            state_d    = S_FILL;
            sum_d      = '0;
            fill_cnt_d = '0;
            edge_cnt_d = '0;
            qual_cnt_d = '0;
            level_d    = 1'b0;
        end else begin
            if (do_eval) begin
                if (cand != level_q) begin
                    if (qual_p1 >= {1'b0, qual_eff}) begin
                        level_d    = cand;
                        qual_cnt_d = '0;
                        if (edge_match) begin
                            if (edge_p1 == {1'b0, edge_num_eff}) begin
                                trig_d     = 1'b1;
                                edge_cnt_d = '0;
                                if (!cfg_rearm) begin
                                    state_d = S_DONE;
                                end
                            end else begin
                                edge_cnt_d = edge_p1[CNT_WIDTH-1:0];
                            end
                        end
                    end else begin
                        qual_cnt_d = qual_p1[CNT_WIDTH-1:0];
                    end
                end else begin
                    qual_cnt_d = '0;
                end
            end

            if (accept) begin
                sum_d       = sum_calc;
                sum_valid_d = 1'b1;
                wr_ptr_d    = wr_ptr_q + WIN_LOG2'(1);
                eval_d      = (state_q == S_ARMED);
                if (fill_cnt_q < win_eff) begin
                    fill_cnt_d = fill_p1;
                end
                if ((state_q == S_FILL) && (fill_p1 == win_eff)) begin
                    state_d = S_ARMED;
                    level_d = (sum_calc > cfg_thresh_hi);
                end
            end
        end
    end

    // state and datapath registers
    always_ff @(posedge clk or posedge reset_i) begin
        if (reset_i) begin
            state_q     <= S_IDLE;
            wr_ptr_q    <= '0;
            fill_cnt_q  <= '0;
            sum_q       <= '0;
            sum_valid_q <= 1'b0;
            eval_q      <= 1'b0;
            level_q     <= 1'b0;
            trig_q      <= 1'b0;
            edge_cnt_q  <= '0;
            qual_cnt_q  <= '0;
        end else begin
            state_q     <= state_d;
            wr_ptr_q    <= wr_ptr_d;
            fill_cnt_q  <= fill_cnt_d;
            sum_q       <= sum_d;
            sum_valid_q <= sum_valid_d;
            eval_q      <= eval_d;
            level_q     <= level_d;
            trig_q      <= trig_d;
            edge_cnt_q  <= edge_cnt_d;
            qual_cnt_q  <= qual_cnt_d;
        end
    end

    // sample history write
    always_ff @(posedge clk) begin
        if (accept) begin
            mem[wr_ptr_q] <= sample;
        end
    end

    assign trig_out   = trig_q;
    assign sum_out    = sum_q;
    assign sum_valid  = sum_valid_q;
    assign level_o    = level_q;
    assign edge_cnt_o = edge_cnt_q;
    assign state_o    = state_q;

endmodule

// File: tb/tb_edge_trigger_hyst.sv
// tb/tb_edge_trigger_hyst.sv - scoreboard bench for edge_trigger_hyst

module tb_edge_trigger_hyst;

    localparam int ADC_WIDTH = 10;
    localparam int WIN_LOG2  = 8;
    localparam int CNT_WIDTH = 8;
    localparam int SUM_WIDTH = ADC_WIDTH + WIN_LOG2;

    logic                 clk = 1'b0;
    logic                 reset_i = 1'b1;
    logic [ADC_WIDTH-1:0] adc_data = '0;
    logic                 adc_valid = 1'b0;
    logic                 cfg_arm = 1'b0;
    logic                 cfg_abort = 1'b0;
    logic [WIN_LOG2-1:0]  cfg_window = '0;
    logic                 cfg_abs = 1'b0;
    logic [1:0]           cfg_mode = '0;
    logic [SUM_WIDTH-1:0] cfg_thresh_hi = '0;
    logic [SUM_WIDTH-1:0] cfg_thresh_lo = '0;
    logic [CNT_WIDTH-1:0] cfg_qualify = '0;
    logic [CNT_WIDTH-1:0] cfg_edge_num = '0;
    logic                 cfg_rearm = 1'b0;
    logic                 trig_out;
    logic [SUM_WIDTH-1:0] sum_out;
    logic                 sum_valid;
    logic                 level_o;
    logic [CNT_WIDTH-1:0] edge_cnt_o;
    logic [1:0]           state_o;

    edge_trigger_hyst #(
        .ADC_WIDTH (ADC_WIDTH),
        .WIN_LOG2  (WIN_LOG2),
        .CNT_WIDTH (CNT_WIDTH)
    ) dut (
        .clk           (clk),
        .reset_i       (reset_i),
        .adc_data      (adc_data),
        .adc_valid     (adc_valid),
        .cfg_arm       (cfg_arm),
        .cfg_abort     (cfg_abort),
        .cfg_window    (cfg_window),
        .cfg_abs       (cfg_abs),
        .cfg_mode      (cfg_mode),
        .cfg_thresh_hi (cfg_thresh_hi),
        .cfg_thresh_lo (cfg_thresh_lo),
        .cfg_qualify   (cfg_qualify),
        .cfg_edge_num  (cfg_edge_num),
        .cfg_rearm     (cfg_rearm),
        .trig_out      (trig_out),
        .sum_out       (sum_out),
        .sum_valid     (sum_valid),
        .level_o       (level_o),
        .edge_cnt_o    (edge_cnt_o),
        .state_o       (state_o)
    );

    always #5 clk = ~clk;

    typedef struct {
        int sum;
        int trig;
        int level;
        int edge_c;
        int state;
    } exp_t;

    exp_t exp_q[$];
    exp_t pend;
    bit   pend_valid = 1'b0;
    int   total = 0;
    int   bad = 0;
    int   trig_seen = 0;

    // reference model state, advanced once per accepted sample
    int m_state = 0;
    int hist[$];
    int m_level = 0;
    int m_qual = 0;
    int m_edge = 0;

    function automatic int eff(input int v);
        return (v == 0) ? 1 : v;
    endfunction

    task automatic chk(input string name, input int act, input int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic model_sample(input int raw, input bit abort_after);
        int   s, n, sum, cand;
        bit   tog, match;
        exp_t e;
        if (m_state == 0) return;
        s = cfg_abs ? ((raw >= 512) ? raw - 512 : 512 - raw) : raw;
        hist.push_back(s);
        n = eff(int'(cfg_window));
        sum = 0;
        for (int i = 0; i < n && i < hist.size(); i++) sum += hist[hist.size()-1-i];
        e.trig = 0;
        if (m_state == 1) begin
            if (hist.size() == n) begin
                m_level = (sum > int'(cfg_thresh_hi)) ? 1 : 0;
                m_state = 2;
            end
        end else if (m_state == 2 && !abort_after) begin
            cand = (sum > int'(cfg_thresh_hi)) ? 1 : (sum < int'(cfg_thresh_lo)) ? 0 : m_level;
            tog = 1'b0;
            if (cand != m_level) begin
                m_qual++;
                if (m_qual >= eff(int'(cfg_qualify))) begin
                    m_level = cand;
                    m_qual = 0;
                    tog = 1'b1;
                end
            end else begin
                m_qual = 0;
            end
            match = (cfg_mode == 2) || ((cfg_mode == 1) ? (m_level == 0) : (m_level == 1));
            if (tog && match) begin
                m_edge++;
                if (m_edge == eff(int'(cfg_edge_num))) begin
                    e.trig = 1;
                    m_edge = 0;
                    if (!cfg_rearm) m_state = 3;
                end
            end
        end
        if (abort_after) m_state = 0;
        if (hist.size() > 300) void'(hist.pop_front());
        e.sum = sum;
        e.level = m_level;
        e.edge_c = m_edge;
        e.state = m_state;
        exp_q.push_back(e);
    endtask

    task automatic send_sample(input int raw, input bit abort_after, input int gap);
        @(posedge clk); #1;
        adc_data = raw[ADC_WIDTH-1:0];
        adc_valid = 1'b1;
        model_sample(raw, abort_after);
        @(posedge clk); #1;
        adc_valid = 1'b0;
        if (abort_after) begin
            cfg_abort = 1'b1;
            @(posedge clk); #1;
            cfg_abort = 1'b0;
        end
        repeat (gap) begin
            @(posedge clk); #1;
        end
    endtask

    task automatic do_arm();
        @(posedge clk); #1;
        cfg_arm = 1'b1;
        m_state = 1;
        hist.delete();
        m_level = 0;
        m_qual = 0;
        m_edge = 0;
        @(posedge clk); #1;
        cfg_arm = 1'b0;
    endtask

    task automatic do_abort();
        @(posedge clk); #1;
        cfg_abort = 1'b1;
        m_state = 0;
        @(posedge clk); #1;
        cfg_abort = 1'b0;
    endtask

    task automatic set_cfg(input int win, input int ab, input int mode, input int hi, input int lo,
                           input int q, input int en, input int rearm);
        cfg_window = win[WIN_LOG2-1:0];
        cfg_abs = ab[0];
        cfg_mode = mode[1:0];
        cfg_thresh_hi = hi[SUM_WIDTH-1:0];
        cfg_thresh_lo = lo[SUM_WIDTH-1:0];
        cfg_qualify = q[CNT_WIDTH-1:0];
        cfg_edge_num = en[CNT_WIDTH-1:0];
        cfg_rearm = rearm[0];
    endtask

    task automatic settle();
        repeat (3) @(posedge clk);
        #4;
    endtask

    // monitor: per-cycle trigger check, sum check on sum_valid, post-commit check one cycle later
    always @(negedge clk) begin
        if (pend_valid) begin
            chk("trig", int'(trig_out), pend.trig);
            chk("level", int'(level_o), pend.level);
            chk("edge_cnt", int'(edge_cnt_o), pend.edge_c);
            chk("state", int'(state_o), pend.state);
            pend_valid = 1'b0;
        end else begin
            chk("idle_trig", int'(trig_out), 0);
        end
        if (trig_out) trig_seen++;
        if (sum_valid) begin
            if (exp_q.size() == 0) begin
                chk("unexpected_sum_valid", 1, 0);
            end else begin
                pend = exp_q.pop_front();
                chk("sum", int'(sum_out), pend.sum);
                pend_valid = 1'b1;
            end
        end
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int t0, n, mean, hi, lo;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_state", int'(state_o), 0);
        chk("rst_sum", int'(sum_out), 0);
        chk("rst_sum_valid", int'(sum_valid), 0);
        chk("rst_level", int'(level_o), 0);
        chk("rst_edge", int'(edge_cnt_o), 0);
        chk("rst_trig", int'(trig_out), 0);
        reset_i = 1'b0;

        // fill window 4
        set_cfg(4, 0, 0, 1000, 0, 1, 1, 0);
        t0 = trig_seen;
        do_arm();
        #4 chk("arm_state", int'(state_o), 1);
        send_sample(10, 0, 0);
        send_sample(20, 0, 0);
        send_sample(30, 0, 0);
        send_sample(40, 0, 0);
        send_sample(50, 0, 1);
        settle();
        chk("t1_sum", int'(sum_out), 140);
        chk("t1_state", int'(state_o), 2);
        chk("t1_trigs", trig_seen - t0, 0);

        // simple rising trigger
        do_abort();
        set_cfg(1, 0, 0, 200, 100, 1, 1, 0);
        t0 = trig_seen;
        do_arm();
        send_sample(150, 0, 1);
        send_sample(210, 0, 1);
        settle();
        chk("t2_state", int'(state_o), 3);
        chk("t2_trigs", trig_seen - t0, 1);

        // hysteresis, edge_num 2
        do_abort();
        set_cfg(1, 0, 0, 200, 100, 1, 2, 0);
        t0 = trig_seen;
        do_arm();
        send_sample(210, 0, 1);
        send_sample(150, 0, 1);
        send_sample(210, 0, 1);
        send_sample(90, 0, 1);
        send_sample(210, 0, 1);
        settle();
        chk("t3_edge", int'(edge_cnt_o), 1);
        chk("t3_level", int'(level_o), 1);
        chk("t3_trigs", trig_seen - t0, 0);

        // qualification of 3
        do_abort();
        set_cfg(1, 0, 0, 200, 100, 3, 1, 0);
        t0 = trig_seen;
        do_arm();
        send_sample(150, 0, 0);
        send_sample(210, 0, 0);
        send_sample(210, 0, 0);
        send_sample(90, 0, 0);
        send_sample(210, 0, 0);
        send_sample(210, 0, 0);
        send_sample(210, 0, 1);
        settle();
        chk("t4_trigs", trig_seen - t0, 1);
        chk("t4_state", int'(state_o), 3);

        // both edges, every 3rd, re-arm
        do_abort();
        set_cfg(1, 0, 2, 200, 100, 1, 3, 1);
        t0 = trig_seen;
        do_arm();
        send_sample(150, 0, 0);
        for (int i = 0; i < 6; i++) send_sample((i % 2 == 0) ? 210 : 90, 0, 0);
        settle();
        chk("t5_trigs", trig_seen - t0, 2);
        chk("t5_state", int'(state_o), 2);
        chk("t5_edge", int'(edge_cnt_o), 0);

        // abort on the trigger cycle, then arm+abort together, then an IDLE sample
        do_abort();
        set_cfg(1, 0, 0, 200, 100, 1, 1, 0);
        t0 = trig_seen;
        do_arm();
        send_sample(150, 0, 1);
        send_sample(210, 1, 1);
        settle();
        chk("t6_state", int'(state_o), 0);
        chk("t6_trigs", trig_seen - t0, 0);
        do_arm();
        send_sample(150, 0, 1);
        @(posedge clk); #1;
        cfg_arm = 1'b1;
        cfg_abort = 1'b1;
        m_state = 0;
        @(posedge clk); #1;
        cfg_arm = 1'b0;
        cfg_abort = 1'b0;
        #3 chk("t6_arm_abort_state", int'(state_o), 0);
        send_sample(300, 0, 2);

        // async reset mid-fill
        set_cfg(4, 0, 0, 1000, 0, 1, 1, 0);
        do_arm();
        send_sample(100, 0, 0);
        send_sample(200, 0, 2);
        @(posedge clk); #3;
        reset_i = 1'b1;
        #1;
        chk("t7_state", int'(state_o), 0);
        chk("t7_sum", int'(sum_out), 0);
        chk("t7_sum_valid", int'(sum_valid), 0);
        chk("t7_level", int'(level_o), 0);
        chk("t7_edge", int'(edge_cnt_o), 0);
        chk("t7_trig", int'(trig_out), 0);
        m_state = 0;
        @(posedge clk); #1;
        reset_i = 1'b0;

        // randomized captures
        for (int r = 0; r < 8; r++) begin
            do_abort();
            n = int'($urandom_range(0, 6));
            mean = eff(n) * ((r % 2 == 1) ? 256 : 512);
            hi = mean + int'($urandom_range(0, 150)) * eff(n);
            lo = mean - int'($urandom_range(0, 150)) * eff(n);
            if (lo < 0) lo = 0;
            set_cfg(n, r % 2, int'($urandom_range(0, 3)), hi, lo, int'($urandom_range(0, 3)),
                    int'($urandom_range(0, 3)), int'($urandom_range(0, 1)));
            do_arm();
            for (int k = 0; k < 40; k++) begin
                if ($urandom_range(0, 24) == 0) do_arm();
                send_sample(int'($urandom_range(0, 1023)), 1'b0, int'($urandom_range(0, 2)));
            end
        end

        settle();
        chk("queue_empty", exp_q.size(), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/edge_trigger_hyst.md
Name: edge_trigger_hyst

Overview:
- Parametrised edge-trigger core that replaces the fixed-width HLS moving-sum edge trigger with native RTL in one clock domain.
- Computes a moving sum of ADC samples over a runtime window, then derives a level using a two-threshold hysteresis comparator with a qualification count.
- Counts qualified rising, falling or both edges, and emits a one-cycle trigger on the Nth edge. Supports abort and optional auto re-arm.
- Sits between the ADC sample stream and the trigger mux; a register wrapper drives all cfg_* inputs.

Parameters:
ADC_WIDTH, 10, sample width; unsigned.
WIN_LOG2, 8, log2 of the sample buffer depth; maximum window is 2^WIN_LOG2-1 samples.
CNT_WIDTH, 8, width of the edge and qualification counters.
(derived) SUM_WIDTH = ADC_WIDTH+WIN_LOG2; the moving sum cannot overflow.

Ports:
clk  in  1  ADC sample clock; sole clock.
reset_i  in  1  asynchronous, active-high; clears all state.
adc_data  in  ADC_WIDTH  sample.
adc_valid  in  1  sample strobe.
cfg_arm  in  1  pulse; starts or restarts a capture.
cfg_abort  in  1  pulse; returns the block to IDLE.
cfg_window  in  WIN_LOG2  window length N; 0 is treated as 1.
cfg_abs  in  1  1 = use |adc_data - 2^(ADC_WIDTH-1)| as the sample.
cfg_mode  in  2  0 rising, 1 falling, 2 both, 3 treated as rising.
cfg_thresh_hi  in  SUM_WIDTH  level goes high when sum > hi.
cfg_thresh_lo  in  SUM_WIDTH  level goes low when sum < lo.
cfg_qualify  in  CNT_WIDTH  consecutive valid sums required to commit a level change; 0 is treated as 1.
cfg_edge_num  in  CNT_WIDTH  trigger on this qualified edge; 0 is treated as 1.
cfg_rearm  in  1  1 = return to ARMED after a trigger.
trig_out  out  1  single-cycle trigger pulse.
sum_out  out  SUM_WIDTH  registered moving sum.
sum_valid  out  1  sum_out was updated this cycle.
level_o  out  1  committed hysteresis level.
edge_cnt_o  out  CNT_WIDTH  qualified edges counted since arm or re-arm.
state_o  out  2  0 IDLE, 1 FILL, 2 ARMED, 3 DONE.

Behaviour:
Reset:
- All outputs are 0, state is IDLE, and the buffer write pointer is 0.
- Buffer contents are don't-care; the fill logic masks them.

Moving sum:
- On adc_valid, s = cfg_abs ? abs-from-midscale : adc_data.
- s is written into a 2^WIN_LOG2 circular buffer.
- sum <= sum + s - s_old, where s_old is the sample written N strobes earlier. s_old is 0 while fill_cnt < N.
- sum_out and sum_valid register 1 clk after the adc_valid cycle.
- sum_valid asserts only when adc_valid is seen in FILL, ARMED or DONE. Samples arriving in IDLE are ignored.
- cfg_window, cfg_abs and the thresholds may only change in IDLE; otherwise behaviour is undefined.

States:
- IDLE -> FILL on cfg_arm. This clears sum, fill_cnt, edge_cnt, qual_cnt and level.
- FILL: fill_cnt increments per strobe. On the strobe that makes fill_cnt == N, level is initialised to (new sum > hi) without counting an edge, and the state moves to ARMED.
- ARMED: candidate level is 1 if sum > hi, 0 if sum < lo, and the current level otherwise; if both thresholds are met, hi wins. If candidate != level, qual_cnt increments per sum_valid, otherwise qual_cnt clears. When qual_cnt reaches cfg_qualify, level toggles and qual_cnt clears.
- A level toggle matching cfg_mode is an edge, and edge_cnt increments. If edge_cnt+1 == cfg_edge_num, trig_out pulses on the same clk as the commit and edge_cnt clears. The state then moves to DONE, or stays ARMED if cfg_rearm = 1.
- DONE: the sum keeps updating, no edges are counted, and the block holds until cfg_arm or cfg_abort.

Latency:
- adc_valid at cycle t gives sum_out at t+1.
- The commit and trig_out occur at t+2.

Boundaries:
- cfg_abort from any state goes to IDLE, with no trig_out that cycle.
- If cfg_arm and cfg_abort are asserted together, abort wins.
- cfg_arm outside IDLE restarts: go to FILL and clear as above.
- Toggles not matching cfg_mode update level but do not count.
- edge_cnt never wraps, because the compare fires first.
- Async reset mid-capture: trig_out drops immediately and nothing is retained.

Test Plan:
- N=4, abs=0, samples 10,20,30,40,50 -> sum_valid at 4th strobe with sum 100, 5th sum 140; state FILL->ARMED on 4th; no trig_out.
- Rising, hi=200, lo=100, qualify=1, edge_num=1; ramp sums 150,210 -> trig_out 1 clk after sum 210; state DONE.
- Hysteresis: sums 210,150,210,90,210 with rising, edge_num=2 -> first edge at initial 210 is not counted; counted edges are at the 5th sum only, so edge_cnt_o=1 and no trigger; verify level_o=0 only after 90.
- Qualify=3: sum above hi for 2 samples then below lo -> no edge; 3 consecutive above -> edge on the 3rd.
- Mode both, edge_num=3, rearm=1 -> trig_out every 3rd toggle, state stays ARMED, edge_cnt_o returns to 0.
- Abort asserted the same cycle a trigger would fire, and simultaneous arm+abort -> no trig_out, state IDLE; async reset mid-FILL -> all outputs 0.
